// File: rtl/id_ex_pkg.sv
// id_ex_pkg: control bundle, skid-buffer state and shared constants for the ID/EX stage
package id_ex_pkg;
    typedef struct packed {
        logic       branch_b;
        logic       branch_i;
        logic       branch_geq;
        logic       branch_leq;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] alu_op;
        logic       alu_src;
        logic       reg_write;
    } ctrl_t;
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} skid_state_t;
    localparam ctrl_t CTRL_NOP = '0;
    localparam int CTRL_W = $bits(ctrl_t);
endpackage

// File: rtl/pipe_skid_buffer.sv
// pipe_skid_buffer: 2-entry valid/ready skid buffer with flush; the main entry drives the output
module pipe_skid_buffer
    import id_ex_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    skid_state_t state;
    logic [WIDTH-1:0] skid;
    logic in_fire, out_fire;
    assign out_valid = (state == ONE) | (state == FULL);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    // in_ready is registered alongside the state so it never depends on out_ready combinationally
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            in_ready <= 1'b0;
            out_data <= '0;
            skid     <= '0;
        end else if (flush) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            in_ready <= 1'b1;
            case (state)
                EMPTY: if (in_fire) begin
                    state    <= ONE;
                    out_data <= in_data;
                end
                ONE: if (in_fire && out_fire) begin
                    out_data <= in_data;
                end else if (in_fire) begin
                    state    <= FULL;
                    skid     <= in_data;
                    in_ready <= 1'b0;
                end else if (out_fire) begin
                    state    <= EMPTY;
                end
                FULL: if (out_fire) begin
                    state    <= ONE;
                    out_data <= skid;
                end else begin
                    in_ready <= 1'b0;
                end
                default: state <= EMPTY;
            endcase
        end
    end
endmodule

// File: rtl/id_ex_skid_stage.sv
// id_ex_skid_stage: ID/EX pipeline register with valid/ready skid buffering, flush and stall counter
module id_ex_skid_stage
    import id_ex_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int NUM_OPS = 3,
    parameter int REG_AW  = 4,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  ctrl_t                     in_ctrl,
    input  logic [DATA_W-1:0]         in_pc,
    input  logic [NUM_OPS*DATA_W-1:0] in_ops,
    input  logic [REG_AW-1:0]         in_rd,
    input  logic [DATA_W-1:0]         in_imm,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output ctrl_t                     out_ctrl,
    output logic [DATA_W-1:0]         out_pc,
    output logic [NUM_OPS*DATA_W-1:0] out_ops,
    output logic [REG_AW-1:0]         out_rd,
    output logic [DATA_W-1:0]         out_imm,
    output logic [CNT_W-1:0]          stall_cnt
);
    localparam int W = CTRL_W + 2*DATA_W + NUM_OPS*DATA_W + REG_AW;
    logic [W-1:0] out_data;
    ctrl_t main_ctrl;
    pipe_skid_buffer #(.WIDTH(W)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({in_ctrl, in_pc, in_ops, in_rd, in_imm}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );
    assign {main_ctrl, out_pc, out_ops, out_rd, out_imm} = out_data;
    // stale payload after a flush is harmless because the control bundle is forced to a NOP
    assign out_ctrl = out_valid ? main_ctrl : CTRL_NOP;
    always_ff @(negedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && stall_cnt != {CNT_W{1'b1}})
            stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_id_ex_skid_stage.sv
// tb_id_ex_skid_stage: directed tests for the ID/EX skid stage (wide CNT_W=4 build and narrow 2-op build)
module tb_id_ex_skid_stage;
    import id_ex_pkg::*;
    logic clk, rst;
    logic in_valid, in_ready, flush, out_valid, out_ready;
    ctrl_t in_ctrl, out_ctrl;
    logic [31:0] in_pc, in_imm, out_pc, out_imm;
    logic [95:0] in_ops, out_ops;
    logic [3:0] in_rd, out_rd, stall_cnt;
    logic in_valid2, in_ready2, flush2, out_valid2, out_ready2;
    ctrl_t in_ctrl2, out_ctrl2;
    logic [15:0] in_pc2, in_imm2, out_pc2, out_imm2, stall_cnt2;
    logic [31:0] in_ops2, out_ops2;
    logic [3:0] in_rd2, out_rd2;
    int passed = 0;
    int total = 0;

    id_ex_skid_stage #(.DATA_W(32), .NUM_OPS(3), .REG_AW(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
        .in_pc(in_pc), .in_ops(in_ops), .in_rd(in_rd), .in_imm(in_imm), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_pc(out_pc),
        .out_ops(out_ops), .out_rd(out_rd), .out_imm(out_imm), .stall_cnt(stall_cnt)
    );
    id_ex_skid_stage #(.DATA_W(16), .NUM_OPS(2), .REG_AW(4), .CNT_W(16)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_ctrl(in_ctrl2),
        .in_pc(in_pc2), .in_ops(in_ops2), .in_rd(in_rd2), .in_imm(in_imm2), .flush(flush2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_ctrl(out_ctrl2), .out_pc(out_pc2),
        .out_ops(out_ops2), .out_rd(out_rd2), .out_imm(out_imm2), .stall_cnt(stall_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_pc = '0; in_ops = '0; in_rd = '0; in_imm = '0;
        in_valid2 = 1'b0; flush2 = 1'b0; out_ready2 = 1'b0;
        in_ctrl2 = '0; in_pc2 = '0; in_ops2 = '0; in_rd2 = '0; in_imm2 = '0;
        #2;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready); else passed++;
        total++; if (stall_cnt !== 4'd0) $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); else passed++;
        step();
        step();
        total++; if (in_ready !== 1'b0) $display("FAIL reset_held_in_ready got %b want 0", in_ready); else passed++;
        rst = 1'b0;
        step();
        total++; if (in_ready !== 1'b1) $display("FAIL reset_release_in_ready got %b want 1", in_ready); else passed++;
        total++; if (out_pc !== 32'd0) $display("FAIL reset_out_pc got %h want 0", out_pc); else passed++;
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_pc = 32'(4 * i);
            in_ctrl = ctrl_t'(12'(i * 37 + 5));
            in_ops = {32'(i + 300), 32'(i + 200), 32'(i + 100)};
            in_rd = 4'(i + 1);
            in_imm = 32'(i * 1000);
            step();
            total++; if (out_pc !== 32'(4 * i)) $display("FAIL stream_pc[%0d] got %h want %h", i, out_pc, 32'(4 * i)); else passed++;
            total++; if (out_ctrl !== ctrl_t'(12'(i * 37 + 5))) $display("FAIL stream_ctrl[%0d] got %h want %h", i, out_ctrl, 12'(i * 37 + 5)); else passed++;
            total++; if (in_ready !== 1'b1) $display("FAIL stream_in_ready[%0d] got %b want 1", i, in_ready); else passed++;
        end
        total++; if (out_ops !== {32'd307, 32'd207, 32'd107}) $display("FAIL stream_ops got %h want %h", out_ops, {32'd307, 32'd207, 32'd107}); else passed++;
        total++; if (out_rd !== 4'd8 || out_imm !== 32'd7000) $display("FAIL stream_rd_imm got %h/%h want 8/1b58", out_rd, out_imm); else passed++;
        in_valid = 1'b0;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL stream_drain_valid got %b want 0", out_valid); else passed++;
        total++; if (stall_cnt !== 4'd0) $display("FAIL stream_stall_cnt got %0d want 0", stall_cnt); else passed++;
    endtask

    task automatic test_backpressure();
        apply_reset();
        in_valid = 1'b1; in_pc = 32'h10; in_ctrl = ctrl_t'(12'h0A1);
        step();
        in_pc = 32'h14; in_ctrl = ctrl_t'(12'h0B2);
        step();
        total++; if (in_ready !== 1'b0) $display("FAIL bp_full_in_ready got %b want 0", in_ready); else passed++;
        in_pc = 32'h99;
        step();
        step();
        total++; if (stall_cnt !== 4'd3) $display("FAIL bp_stall_cnt got %0d want 3", stall_cnt); else passed++;
        total++; if (out_pc !== 32'h10) $display("FAIL bp_hold_pc got %h want 10", out_pc); else passed++;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h14) $display("FAIL bp_second_pc got %b/%h want 1/14", out_valid, out_pc); else passed++;
        total++; if (out_ctrl !== ctrl_t'(12'h0B2)) $display("FAIL bp_second_ctrl got %h want 0b2", out_ctrl); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL bp_release_in_ready got %b want 1", in_ready); else passed++;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL bp_no_duplicate got %b want 0", out_valid); else passed++;
        total++; if (stall_cnt !== 4'd3) $display("FAIL bp_stall_after got %0d want 3", stall_cnt); else passed++;
    endtask

    task automatic test_flush();
        apply_reset();
        in_valid = 1'b1; in_pc = 32'h20; in_ctrl = ctrl_t'(12'hFFF);
        step();
        in_pc = 32'h24;
        step();
        flush = 1'b1; in_pc = 32'h28;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid got %b want 0", out_valid); else passed++;
        total++; if (out_ctrl !== CTRL_NOP) $display("FAIL flush_out_ctrl got %h want 0", out_ctrl); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL flush_in_ready got %b want 1", in_ready); else passed++;
        total++; if (out_pc !== 32'h20) $display("FAIL flush_stale_pc got %h want 20", out_pc); else passed++;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL flush_discard got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_saturate();
        apply_reset();
        in_valid = 1'b1; in_pc = 32'h30;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 21; i++) step();
        total++; if (stall_cnt !== 4'd15) $display("FAIL sat_stall_cnt got %0d want 15", stall_cnt); else passed++;
        flush = 1'b1;
        step();
        flush = 1'b0;
        total++; if (stall_cnt !== 4'd15) $display("FAIL sat_after_flush got %0d want 15", stall_cnt); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL sat_flush_valid got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_reset_mid_full();
        apply_reset();
        in_valid = 1'b1; in_pc = 32'h40; in_ctrl = ctrl_t'(12'h123);
        step();
        in_pc = 32'h44;
        step();
        in_valid = 1'b0;
        total++; if (in_ready !== 1'b0 || stall_cnt !== 4'd1) $display("FAIL rmid_pre got %b/%0d want 0/1", in_ready, stall_cnt); else passed++;
        #2 rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0 || out_pc !== 32'd0) $display("FAIL rmid_out got %b/%h want 0/0", out_valid, out_pc); else passed++;
        total++; if (out_ctrl !== CTRL_NOP || stall_cnt !== 4'd0) $display("FAIL rmid_ctrl_cnt got %h/%0d want 0/0", out_ctrl, stall_cnt); else passed++;
        #3 rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b0) $display("FAIL rmid_in_ready_low got %b want 0", in_ready); else passed++;
        step();
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL rmid_after_edge got %b/%b want 1/0", in_ready, out_valid); else passed++;
    endtask

    task automatic test_narrow();
        in_valid2 = 1'b1; out_ready2 = 1'b1;
        in_ops2 = 32'hBEEF_1234; in_pc2 = 16'h0100; in_rd2 = 4'd9; in_imm2 = 16'hA5A5;
        in_ctrl2 = '0;
        in_ctrl2.reg_write = 1'b1;
        in_ctrl2.alu_op = 3'b101;
        step();
        in_valid2 = 1'b0;
        total++; if (out_ops2 !== 32'hBEEF_1234) $display("FAIL narrow_ops got %h want beef1234", out_ops2); else passed++;
        total++; if (out_ctrl2 !== ctrl_t'(12'h015)) $display("FAIL narrow_ctrl got %h want 015", out_ctrl2); else passed++;
        total++; if (out_pc2 !== 16'h0100 || out_rd2 !== 4'd9 || out_imm2 !== 16'hA5A5) $display("FAIL narrow_payload got %h/%h/%h want 0100/9/a5a5", out_pc2, out_rd2, out_imm2); else passed++;
        step();
        total++; if (out_valid2 !== 1'b0 || out_ctrl2 !== CTRL_NOP) $display("FAIL narrow_drain got %b/%h want 0/0", out_valid2, out_ctrl2); else passed++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_saturate();
        test_reset_mid_full();
        test_narrow();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/id_ex_skid_stage.md
Name: id_ex_skid_stage

Overview:
Parametrised ID/EX pipeline stage register for the project_1 pipeline.
- Carries the decoded control bundle plus the PC, N operand words, destination register address and immediate from decode to execute.
- Replaces the free-running latch with a valid/ready handshake and a 2-entry skid buffer, so decode may stall or be back-pressured without losing an instruction.
- Adds flush (bubble insertion) and a saturating stall-cycle counter for performance debug.

Parameters:
DATA_W, 32, width of pc, each operand word and immediate
NUM_OPS, 3, number of register-read operand words carried (RD1..RDn)
REG_AW, 4, width of destination register address
CNT_W, 16, width of stall-cycle counter

Ports:
clk  in  1  stage clock; all state updates on negedge clk (matches rest of pipeline)
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  decode presents a valid instruction
in_ready  out  1  stage can accept; registered, equals (state != FULL)
in_ctrl  in  ctrl_t (12)  decoded control bundle
in_pc  in  DATA_W  instruction PC
in_ops  in  NUM_OPS*DATA_W  operand words, op0 in LSBs
in_rd  in  REG_AW  destination register address
in_imm  in  DATA_W  immediate
flush  in  1  discard all held instructions (branch taken)
out_valid  out  1  main entry holds a valid instruction
out_ready  in  1  execute consumes out this cycle
out_ctrl  out  ctrl_t  main-entry control; forced all-zero when out_valid=0
out_pc, out_ops, out_rd, out_imm  out  as inputs  main-entry payload
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready; both sampled at negedge clk.
- Storage: main entry (drives outputs) and skid entry; state EMPTY / ONE / FULL.
- Transitions (flush=0):
  - EMPTY: in_fire -> ONE, main<=in; else EMPTY.
  - ONE: in_fire & out_fire -> ONE, main<=in. in_fire & !out_fire -> FULL, skid<=in. !in_fire & out_fire -> EMPTY. Otherwise hold.
  - FULL: in_ready=0, so no in_fire. out_fire -> ONE, main<=skid. Otherwise hold.
- Latency: instruction accepted at edge k is visible on out_* after edge k when the stage was EMPTY, or ONE with out_fire. Order is strictly FIFO.
- in_ready is registered: it is 1 after any edge leaving state EMPTY or ONE, and 0 in FULL. in_valid with in_ready=0 is ignored; decode must hold its data.
- flush (highest priority):
  - Next edge -> EMPTY, regardless of in_valid or out_ready.
  - Same-edge input is discarded.
  - out_fire on the flush edge still counts as consumed by execute.
  - Payload registers keep stale values; out_ctrl reads zero, so downstream sees a NOP.
- out_ctrl gating is combinational on out_valid. No other output depends combinationally on inputs.
- stall_cnt: +1 each edge with out_valid & !out_ready; saturates at 2^CNT_W-1; not cleared by flush, only by rst.
- Reset: async, immediate. state=EMPTY, in_ready=0 while rst high and 1 at the first edge after release. out_valid=0, out_ctrl=0, out_pc=out_ops=out_rd=out_imm=0, skid=0, stall_cnt=0. Reset mid-transfer drops both entries.
- Illegal state encoding -> EMPTY.

Decomposition:
- Package id_ex_pkg:
  - ctrl_t packed struct {branch_b, branch_i, branch_geq, branch_leq, mem_to_reg, mem_read, mem_write, alu_op[2:0], alu_src, reg_write}.
  - skid_state_t enum {EMPTY, ONE, FULL}.
  - CTRL_NOP constant (all zero).
- Sub-module pipe_skid_buffer: generic WIDTH-bit 2-entry skid buffer with flush.
- id_ex_skid_stage packs ctrl/payload into one vector, instantiates pipe_skid_buffer, and adds ctrl gating and stall_cnt.

Test Plan:
- Reset, then stream 8 instrs (pc=0x0,0x4,...,0x1C) with in_valid=1, out_ready=1 -> each appears one edge later, in order; in_ready stays 1; stall_cnt=0.
- Accept pc=0x10, hold out_ready=0, offer pc=0x14 -> FULL, in_ready=0. Hold 3 edges -> stall_cnt=3. Release -> outputs 0x10 then 0x14, no loss or duplicate.
- FULL with pc=0x20/0x24, assert flush with in_valid=1 (pc=0x28) -> next edge out_valid=0, out_ctrl=0, in_ready=1. pc=0x28 is never output.
- Hold stall for 2^CNT_W+5 edges (CNT_W=4 build) -> stall_cnt stops at 15; a subsequent flush leaves it at 15.
- Assert rst mid-FULL between clock edges -> out_valid, out_pc, out_ctrl and stall_cnt read 0 immediately; in_ready=0 until the first edge after release.
- NUM_OPS=2, DATA_W=16 build: in_ops=0xBEEF_1234 with reg_write=1, alu_op=3'b101 -> out_ops=0xBEEF_1234 and out_ctrl matches input bit for bit.
